frame_buffer_arbiter: RTL and testbench
=======================================

// Module: frame_buffer_arbiter
// PURPOSE
//  Shares the single-port frame_buffer between a raster pixel writer and a random-access
//  pixel reader (window fetch for the edge filter). Round-robin arbitration, one FB op/cycle.
//  Generates wrapping write addresses for the circular P_ROWS-row buffer and returns reads.
// PARAMETERS
//  P_COLUMNS      640  pixels per row; COL_W = $clog2(P_COLUMNS)
//  P_ROWS         3    rows held in frame_buffer; ROW_W = $clog2(P_ROWS)
//  P_PIXEL_DEPTH  24   bits per pixel (RGB 8:8:8)
// PORTS
//  I_CLK              in   1      clock
//  I_RESET            in   1      synchronous active-high reset
//  I_ENABLE           in   1      0 = no new grants; in-flight ops still complete
//  I_FRAME_START      in   1      pulse: restart write pointer at (0,0), clear row count
//  I_WR_VALID         in   1      writer has pixel
//  I_WR_PIXEL         in   DEPTH  pixel to write at internal (col,row)
//  O_WR_READY         out  1      write accepted this cycle (combinational grant)
//  I_RD_VALID         in   1      reader has request
//  I_RD_COL           in   COL_W  read column
//  I_RD_ROW           in   ROW_W  read row
//  O_RD_READY         out  1      read accepted this cycle (combinational grant)
//  O_RD_VALID         out  1      pulse: O_RD_PIXEL holds read result
//  O_RD_PIXEL         out  DEPTH  read result (registered)
//  O_RD_ERR           out  1      with O_RD_VALID: coordinate out of range, pixel = 0
//  O_WR_ROW           out  ROW_W  row the next write lands in
//  O_ROW_DONE         out  1      pulse: last column of a row accepted
//  O_ROWS_VALID       out  ROW_W+1 completed rows since frame start, saturates at P_ROWS
//  O_FB_ENABLE        out  1      frame_buffer I_ENABLE, high only on command cycles
//  O_FB_COL/O_FB_ROW  out  COL_W/ROW_W  frame_buffer address
//  O_FB_PIXEL         out  DEPTH  frame_buffer write data
//  O_FB_WRITE_ENABLE  out  1      frame_buffer write strobe
//  O_FB_READ_ENABLE   out  1      frame_buffer read strobe
//  I_FB_PIXEL         in   DEPTH  frame_buffer O_PIXEL, valid cycle after read strobe
// BEHAVIOUR
//  Reset: all outputs 0, write ptr (0,0), row count 0, priority=WR, read pipe emptied;
//   reset mid-read drops it (no O_RD_VALID). READY outputs 0 while I_RESET or !I_ENABLE.
//  Arbiter FSM, 2 states PRI_WR / PRI_RD (priority holder):
//   both valid -> grant holder; only one valid -> grant it; after any grant priority
//   moves to the other requester; no grant -> state unchanged.
//  Handshake at cycle N (VALID & READY). All FB outputs registered: command in N+1.
//  Write: FB_COL/ROW = write ptr, FB_PIXEL = I_WR_PIXEL, WRITE_ENABLE=1. Ptr col++; at
//   col P_COLUMNS-1 -> col 0, row++ (row P_ROWS-1 wraps to 0), O_ROW_DONE pulses in N+1,
//   O_ROWS_VALID increments in N+1 (saturating). O_WR_ROW updates in N+1.
//  Read: in-range -> READ_ENABLE=1 in N+1, I_FB_PIXEL sampled N+2, O_RD_VALID/PIXEL in
//   N+3 (latency 3). Out-of-range (col>=P_COLUMNS or row>=P_ROWS) -> no FB command,
//   O_RD_VALID+O_RD_ERR in N+3, pixel 0. Reads return strictly in acceptance order.
//  Ordering: FB commands issue in grant order, so read after write to same address in
//   a later cycle returns new data.
//  Idle cycles: FB_ENABLE/WRITE/READ_ENABLE = 0, address/data hold last value.
//  I_FRAME_START: ptr->(0,0), O_ROWS_VALID->0 in next cycle; write granted same cycle
//   goes to (0,0) and ptr becomes (1,0); START wins over row-done increment.
//  I_ENABLE low: no grants, FSM holds; pending read pipe drains normally.
// TESTING
//  1 Reset asserted 2 cycles mid-read -> all outputs 0, no O_RD_VALID afterwards.
//  2 640 consecutive writes -> FB cols 0..639 row 0; O_ROW_DONE once; O_WR_ROW=1; ROWS_VALID=1.
//  3 1921 writes -> row wraps 2->0, ROWS_VALID saturates at 3, 1921st write at (0,0).
//  4 Both valid 4 cycles after reset -> grants W,R,W,R; FB strobes alternate N+1..N+4.
//  5 Write 0xFF0000 to (639,2), then read (639,2) -> O_RD_VALID 3 cycles later, 0xFF0000.
//  6 Read (640,0) -> O_RD_VALID+O_RD_ERR in N+3, pixel 0, no FB_READ_ENABLE issued.

Source files
------------

// File: rtl/frame_buffer_arbiter.sv
// Round-robin arbiter sharing the single-port frame buffer between a raster writer and a
// random-access reader; writes land at a wrapping (col,row) pointer, reads return in order after 3 cycles.
module frame_buffer_arbiter #(
  parameter  int P_COLUMNS     = 640,
  parameter  int P_ROWS        = 3,
  parameter  int P_PIXEL_DEPTH = 24,
  localparam int COL_W         = $clog2(P_COLUMNS),
  localparam int ROW_W         = $clog2(P_ROWS)
) (
  input  logic                     I_CLK,
  input  logic                     I_RESET,
  input  logic                     I_ENABLE,
  input  logic                     I_FRAME_START,
  input  logic                     I_WR_VALID,
  input  logic [P_PIXEL_DEPTH-1:0] I_WR_PIXEL,
  output logic                     O_WR_READY,
  input  logic                     I_RD_VALID,
  input  logic [COL_W-1:0]         I_RD_COL,
  input  logic [ROW_W-1:0]         I_RD_ROW,
  output logic                     O_RD_READY,
  output logic                     O_RD_VALID,
  output logic [P_PIXEL_DEPTH-1:0] O_RD_PIXEL,
  output logic                     O_RD_ERR,
  output logic [ROW_W-1:0]         O_WR_ROW,
  output logic                     O_ROW_DONE,
  output logic [ROW_W:0]           O_ROWS_VALID,
  output logic                     O_FB_ENABLE,
  output logic [COL_W-1:0]         O_FB_COL,
  output logic [ROW_W-1:0]         O_FB_ROW,
  output logic [P_PIXEL_DEPTH-1:0] O_FB_PIXEL,
  output logic                     O_FB_WRITE_ENABLE,
  output logic                     O_FB_READ_ENABLE,
  input  logic [P_PIXEL_DEPTH-1:0] I_FB_PIXEL
);

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(P_COLUMNS - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(P_ROWS - 1);
  localparam logic [ROW_W:0]   ROWS_MAX = (ROW_W + 1)'(P_ROWS);

  typedef enum logic {PRI_WR, PRI_RD} pri_e;

  pri_e pri_q, pri_d;
  logic wr_gnt, rd_gnt, rd_ok;

  logic [COL_W-1:0] col_q, col_d, wr_col;
  logic [ROW_W-1:0] row_q, row_d, wr_row;
  logic [ROW_W:0]   rows_q, rows_d;
  logic             row_end;

  logic                     fb_en_q, fb_we_q, fb_re_q;
  logic [COL_W-1:0]         fb_col_q;
  logic [ROW_W-1:0]         fb_row_q;
  logic [P_PIXEL_DEPTH-1:0] fb_pix_q;
  logic                     row_done_q;

  logic                     p1_vld_q, p1_err_q, p2_vld_q, p2_err_q;
  logic                     rd_vld_q, rd_err_q;
  logic [P_PIXEL_DEPTH-1:0] rd_pix_q;

  always_ff @(posedge I_CLK) begin
    if (I_RESET) pri_q <= PRI_WR;
    else         pri_q <= pri_d;
  end

  // Priority holder wins a collision; a lone requester always wins; priority flips after any grant.
  always_comb begin
    wr_gnt = 1'b0;
    rd_gnt = 1'b0;
    pri_d  = pri_q;
    if (!I_RESET && I_ENABLE) begin
      case (pri_q)
        PRI_WR: begin
          wr_gnt = I_WR_VALID;
          rd_gnt = I_RD_VALID && !I_WR_VALID;
        end
        default: begin
          rd_gnt = I_RD_VALID;
          wr_gnt = I_WR_VALID && !I_RD_VALID;
        end
      endcase
      if (wr_gnt)      pri_d = PRI_RD;
      else if (rd_gnt) pri_d = PRI_WR;
    end
  end

  assign rd_ok = (I_RD_COL <= LAST_COL) && (I_RD_ROW <= LAST_ROW);

  // Frame start redirects a same-cycle write to (0,0) and overrides any row-count increment.
  always_comb begin
    wr_col  = I_FRAME_START ? '0 : col_q;
    wr_row  = I_FRAME_START ? '0 : row_q;
    row_end = wr_gnt && (wr_col == LAST_COL);
    col_d   = wr_col;
    row_d   = wr_row;
    rows_d  = I_FRAME_START ? '0 : rows_q;
    if (wr_gnt) begin
      if (row_end) begin
        col_d = '0;
        row_d = (wr_row == LAST_ROW) ? '0 : wr_row + 1'b1;
        if (!I_FRAME_START && rows_q != ROWS_MAX) rows_d = rows_q + 1'b1;
      end else begin
        col_d = wr_col + 1'b1;
      end
    end
  end

  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      col_q      <= '0;
      row_q      <= '0;
      rows_q     <= '0;
      row_done_q <= 1'b0;
      fb_en_q    <= 1'b0;
      fb_we_q    <= 1'b0;
      fb_re_q    <= 1'b0;
      fb_col_q   <= '0;
      fb_row_q   <= '0;
      fb_pix_q   <= '0;
      p1_vld_q   <= 1'b0;
      p1_err_q   <= 1'b0;
      p2_vld_q   <= 1'b0;
      p2_err_q   <= 1'b0;
      rd_vld_q   <= 1'b0;
      rd_err_q   <= 1'b0;
      rd_pix_q   <= '0;
    end else begin
      col_q      <= col_d;
      row_q      <= row_d;
      rows_q     <= rows_d;
      row_done_q <= row_end;
      fb_en_q    <= wr_gnt || (rd_gnt && rd_ok);
      fb_we_q    <= wr_gnt;
      fb_re_q    <= rd_gnt && rd_ok;
      if (wr_gnt) begin
        fb_col_q <= wr_col;
        fb_row_q <= wr_row;
        fb_pix_q <= I_WR_PIXEL;
      end else if (rd_gnt && rd_ok) begin
        fb_col_q <= I_RD_COL;
        fb_row_q <= I_RD_ROW;
      end
      // Out-of-range reads still travel the pipe so results stay in acceptance order.
      p1_vld_q <= rd_gnt;
      p1_err_q <= rd_gnt && !rd_ok;
      p2_vld_q <= p1_vld_q;
      p2_err_q <= p1_err_q;
      rd_vld_q <= p2_vld_q;
      rd_err_q <= p2_vld_q && p2_err_q;
      if (p2_vld_q) rd_pix_q <= p2_err_q ? '0 : I_FB_PIXEL;
    end
  end

  assign O_WR_READY        = wr_gnt;
  assign O_RD_READY        = rd_gnt;
  assign O_RD_VALID        = rd_vld_q;
  assign O_RD_PIXEL        = rd_pix_q;
  assign O_RD_ERR          = rd_err_q;
  assign O_WR_ROW          = row_q;
  assign O_ROW_DONE        = row_done_q;
  assign O_ROWS_VALID      = rows_q;
  assign O_FB_ENABLE       = fb_en_q;
  assign O_FB_COL          = fb_col_q;
  assign O_FB_ROW          = fb_row_q;
  assign O_FB_PIXEL        = fb_pix_q;
  assign O_FB_WRITE_ENABLE = fb_we_q;
  assign O_FB_READ_ENABLE  = fb_re_q;

endmodule

// File: tb/tb_frame_buffer_arbiter.sv
// Directed bench for frame_buffer_arbiter with a behavioural single-port frame buffer attached.
module tb_frame_buffer_arbiter;
  localparam int COLS = 640;
  localparam int ROWS = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, en, fs, wr_vld, rd_vld;
  logic [23:0] wr_pix;
  logic [9:0]  rd_col;
  logic [1:0]  rd_row;
  logic        wr_rdy, rd_rdy, rd_ovld, rd_err, row_done, fb_en, fb_we, fb_re;
  logic [23:0] rd_pix, fb_pix_o, fb_rdata;
  logic [1:0]  wr_row_o, fb_row;
  logic [2:0]  rows_valid;
  logic [9:0]  fb_col;
  logic [23:0] mem [ROWS][COLS];

  int vectors = 0;
  int errs    = 0;

  frame_buffer_arbiter dut (
    .I_CLK(clk), .I_RESET(rst), .I_ENABLE(en), .I_FRAME_START(fs),
    .I_WR_VALID(wr_vld), .I_WR_PIXEL(wr_pix), .O_WR_READY(wr_rdy),
    .I_RD_VALID(rd_vld), .I_RD_COL(rd_col), .I_RD_ROW(rd_row), .O_RD_READY(rd_rdy),
    .O_RD_VALID(rd_ovld), .O_RD_PIXEL(rd_pix), .O_RD_ERR(rd_err),
    .O_WR_ROW(wr_row_o), .O_ROW_DONE(row_done), .O_ROWS_VALID(rows_valid),
    .O_FB_ENABLE(fb_en), .O_FB_COL(fb_col), .O_FB_ROW(fb_row), .O_FB_PIXEL(fb_pix_o),
    .O_FB_WRITE_ENABLE(fb_we), .O_FB_READ_ENABLE(fb_re), .I_FB_PIXEL(fb_rdata)
  );

  // Frame buffer: read data appears the cycle after the read strobe.
  always @(posedge clk) begin
    if (fb_en && fb_we && fb_row < 2'd3 && fb_col < 10'd640) mem[fb_row][fb_col] <= fb_pix_o;
    if (fb_en && fb_re && fb_row < 2'd3 && fb_col < 10'd640) fb_rdata <= mem[fb_row][fb_col];
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [70:0] outs;
    logic seen;
    rst = 1; en = 1; fs = 0; wr_vld = 1; rd_vld = 1; wr_pix = 24'h123456; rd_col = '0; rd_row = '0;
    tick; tick;
    vectors++;
    if ({wr_rdy, rd_rdy} !== 2'b00) begin
      errs++; $display("FAIL reset_ready: got %b want 00", {wr_rdy, rd_rdy});
    end
    outs = {rd_ovld, rd_err, row_done, fb_en, fb_we, fb_re, fb_col, fb_row, fb_pix_o, rd_pix, wr_row_o, rows_valid};
    vectors++;
    if (outs !== '0) begin
      errs++; $display("FAIL reset_outputs: got %h want 0", outs);
    end
    rst = 0; wr_vld = 0; rd_vld = 1; rd_col = 10'd5; rd_row = 2'd0;
    #1;
    vectors++;
    if (rd_rdy !== 1'b1) begin
      errs++; $display("FAIL reset_rd_accept: got %b want 1", rd_rdy);
    end
    tick;
    rd_vld = 0; rst = 1;
    vectors++;
    if (fb_re !== 1'b1) begin
      errs++; $display("FAIL reset_rd_issued: got %b want 1", fb_re);
    end
    tick;
    vectors++;
    if ({fb_en, fb_re, rd_ovld} !== 3'b000) begin
      errs++; $display("FAIL reset_mid_read_clear: got %b want 000", {fb_en, fb_re, rd_ovld});
    end
    tick;
    rst = 0;
    seen = 0;
    repeat (6) begin
      if (rd_ovld) seen = 1;
      tick;
    end
    vectors++;
    if (seen !== 1'b0) begin
      errs++; $display("FAIL reset_dropped_read: rd_valid seen %b want 0", seen);
    end
  endtask

  task automatic test_row;
    int bad = 0;
    int dones = 0;
    wr_vld = 1;
    for (int i = 0; i < COLS; i++) begin
      wr_pix = 24'(i);
      #1;
      if (wr_rdy !== 1'b1) bad++;
      tick;
      if (fb_col !== 10'(i) || fb_row !== 2'd0 || fb_we !== 1'b1 || fb_en !== 1'b1 ||
          fb_pix_o !== 24'(i) || row_done !== (i == COLS - 1)) bad++;
      if (row_done) dones++;
    end
    wr_vld = 0;
    vectors++;
    if (bad != 0) begin errs++; $display("FAIL row_writes: %0d bad cycles want 0", bad); end
    vectors++;
    if (dones != 1) begin errs++; $display("FAIL row_done_count: got %0d want 1", dones); end
    vectors++;
    if (wr_row_o !== 2'd1) begin errs++; $display("FAIL row_wr_row: got %0d want 1", wr_row_o); end
    vectors++;
    if (rows_valid !== 3'd1) begin errs++; $display("FAIL row_rows_valid: got %0d want 1", rows_valid); end
  endtask

  task automatic test_wrap;
    int bad = 0;
    int dones = 0;
    int exp_rows;
    fs = 1;
    tick;
    fs = 0;
    vectors++;
    if ({wr_row_o, rows_valid} !== 5'd0) begin
      errs++; $display("FAIL wrap_frame_start: row/rows %0d/%0d want 0/0", wr_row_o, rows_valid);
    end
    wr_vld = 1;
    for (int i = 0; i < 3 * COLS + 1; i++) begin
      wr_pix = 24'(i + 1000);
      tick;
      exp_rows = ((i + 1) / COLS > 3) ? 3 : (i + 1) / COLS;
      if (fb_col !== 10'(i % COLS) || fb_row !== 2'((i / COLS) % 3) || fb_we !== 1'b1 ||
          rows_valid !== 3'(exp_rows)) bad++;
      if (row_done) dones++;
    end
    wr_vld = 0;
    vectors++;
    if (bad != 0) begin errs++; $display("FAIL wrap_writes: %0d bad cycles want 0", bad); end
    vectors++;
    if (dones != 3) begin errs++; $display("FAIL wrap_done_count: got %0d want 3", dones); end
    vectors++;
    if ({fb_col, fb_row, rows_valid, wr_row_o} !== {10'd0, 2'd0, 3'd3, 2'd0}) begin
      errs++; $display("FAIL wrap_last: col %0d row %0d rows %0d wr_row %0d want 0 0 3 0",
                       fb_col, fb_row, rows_valid, wr_row_o);
    end
    fs = 1; wr_vld = 1; wr_pix = 24'hABCDEF;
    tick;
    fs = 0; wr_pix = 24'h13579B;
    vectors++;
    if ({fb_col, fb_row, fb_pix_o, rows_valid} !== {10'd0, 2'd0, 24'hABCDEF, 3'd0}) begin
      errs++; $display("FAIL start_with_write: col %0d row %0d pix %h rows %0d want 0 0 abcdef 0",
                       fb_col, fb_row, fb_pix_o, rows_valid);
    end
    tick;
    wr_vld = 0;
    vectors++;
    if ({fb_col, fb_pix_o} !== {10'd1, 24'h13579B}) begin
      errs++; $display("FAIL start_next_write: col %0d pix %h want 1 13579b", fb_col, fb_pix_o);
    end
  endtask

  task automatic test_arb;
    logic [1:0] exp;
    rst = 1;
    tick;
    rst = 0;
    for (int k = 0; k < 4; k++) begin
      wr_vld = 1; rd_vld = 1; rd_col = 10'd3; rd_row = 2'd1; wr_pix = 24'(k);
      exp = (k % 2 == 0) ? 2'b10 : 2'b01;
      #1;
      vectors++;
      if ({wr_rdy, rd_rdy} !== exp) begin
        errs++; $display("FAIL arb_grant_%0d: got %b want %b", k, {wr_rdy, rd_rdy}, exp);
      end
      tick;
      vectors++;
      if ({fb_we, fb_re} !== exp) begin
        errs++; $display("FAIL arb_strobe_%0d: got %b want %b", k, {fb_we, fb_re}, exp);
      end
    end
    en = 0;
    #1;
    vectors++;
    if ({wr_rdy, rd_rdy} !== 2'b00) begin
      errs++; $display("FAIL arb_disabled: got %b want 00", {wr_rdy, rd_rdy});
    end
    tick;
    vectors++;
    if (fb_en !== 1'b0) begin errs++; $display("FAIL arb_disabled_idle: fb_en %b want 0", fb_en); end
    en = 1;
    #1;
    vectors++;
    if ({wr_rdy, rd_rdy} !== 2'b10) begin
      errs++; $display("FAIL arb_hold_priority: got %b want 10", {wr_rdy, rd_rdy});
    end
    tick;
    wr_vld = 0; rd_vld = 0;
    repeat (5) tick;
  endtask

  task automatic test_raw;
    fs = 1; wr_vld = 1;
    for (int i = 0; i < 2 * COLS + COLS; i++) begin
      wr_pix = (i == 3 * COLS - 1) ? 24'hFF0000 : 24'(i + 7);
      tick;
      fs = 0;
    end
    wr_vld = 0;
    vectors++;
    if ({fb_col, fb_row, fb_pix_o} !== {10'd639, 2'd2, 24'hFF0000}) begin
      errs++; $display("FAIL raw_write: col %0d row %0d pix %h want 639 2 ff0000", fb_col, fb_row, fb_pix_o);
    end
    rd_vld = 1; rd_col = 10'd639; rd_row = 2'd2;
    #1;
    vectors++;
    if (rd_rdy !== 1'b1) begin errs++; $display("FAIL raw_rd_accept: got %b want 1", rd_rdy); end
    tick;
    rd_vld = 0;
    vectors++;
    if (rd_ovld !== 1'b0) begin errs++; $display("FAIL raw_early_n1: rd_valid %b want 0", rd_ovld); end
    tick;
    vectors++;
    if (rd_ovld !== 1'b0) begin errs++; $display("FAIL raw_early_n2: rd_valid %b want 0", rd_ovld); end
    tick;
    vectors++;
    if ({rd_ovld, rd_err, rd_pix} !== {1'b1, 1'b0, 24'hFF0000}) begin
      errs++; $display("FAIL raw_result: vld %b err %b pix %h want 1 0 ff0000", rd_ovld, rd_err, rd_pix);
    end
    tick;
  endtask

  task automatic test_back_to_back;
    rd_vld = 1; rd_col = 10'd639; rd_row = 2'd2;
    tick;
    rd_col = 10'd640; rd_row = 2'd0;
    vectors++;
    if (fb_re !== 1'b1) begin errs++; $display("FAIL b2b_inrange_issue: got %b want 1", fb_re); end
    tick;
    rd_col = 10'd5; rd_row = 2'd3;
    vectors++;
    if ({fb_en, fb_re} !== 2'b00) begin
      errs++; $display("FAIL oor_col_no_cmd: en/re %b want 00", {fb_en, fb_re});
    end
    tick;
    rd_vld = 0;
    vectors++;
    if ({rd_ovld, rd_err, rd_pix, fb_en} !== {1'b1, 1'b0, 24'hFF0000, 1'b0}) begin
      errs++; $display("FAIL b2b_first: vld %b err %b pix %h en %b want 1 0 ff0000 0", rd_ovld, rd_err, rd_pix, fb_en);
    end
    tick;
    vectors++;
    if ({rd_ovld, rd_err, rd_pix} !== {1'b1, 1'b1, 24'h0}) begin
      errs++; $display("FAIL oor_col_result: vld %b err %b pix %h want 1 1 0", rd_ovld, rd_err, rd_pix);
    end
    tick;
    vectors++;
    if ({rd_ovld, rd_err, rd_pix} !== {1'b1, 1'b1, 24'h0}) begin
      errs++; $display("FAIL oor_row_result: vld %b err %b pix %h want 1 1 0", rd_ovld, rd_err, rd_pix);
    end
    tick;
    vectors++;
    if ({rd_ovld, rd_err} !== 2'b00) begin
      errs++; $display("FAIL b2b_drained: vld %b err %b want 0 0", rd_ovld, rd_err);
    end
  endtask

  initial begin
    test_reset;
    test_row;
    test_wrap;
    test_arb;
    test_raw;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
